// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the register file's single synchronous write port between the
// fixed-latency ALU writeback and the variable-latency LSU/MUL writeback. It
// also keeps a scoreboard of registers that have a long-latency write in
// flight, so decode can be held on RAW/WAW hazards.
//
// The ALU normally owns the write slot. An LSU beat that loses the slot is
// parked in a one-entry hold buffer. If a parked result waits STARVE_MAX
// cycles, the ALU pipe is frozen for one cycle so the buffer can drain.
//
// Parameters
//   XLEN        write data width
//   STARVE_MAX  cycles a held LSU result may wait before the ALU is frozen (>=1)
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   alu_valid/alu_rd/alu_wdata    ALU writeback beat (no backpressure)
//   alu_stall                     freeze ALU/EX; alu_* ignored while high
//   lsu_valid/lsu_rd/lsu_wdata    LSU writeback beat offered
//   lsu_ready                     LSU beat accepted when valid && ready
//   iss_valid/iss_rs1/iss_rs2/
//   iss_rd/iss_long               instruction presented by decode
//   iss_stall                     decode must hold; instruction not issued
//   rf_we/rf_rd/rf_wdata          registered regfile write port
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  // ALU writeback
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wdata,
  output logic            alu_stall,
  // LSU/MUL writeback
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_wdata,
  // Issue
  input  logic            iss_valid,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic [4:0]      iss_rd,
  input  logic            iss_long,
  output logic            iss_stall,
  // Regfile write port
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  // Who owns the write slot this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_HOLD,
    SRC_LSU
  } src_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic            r_hold_v;
  logic [4:0]      r_hold_rd;
  logic [XLEN-1:0] r_hold_data;
  logic [CW-1:0]   r_starve_cnt;
  // Bit 0 is kept at zero so x0 can be looked up like any other register.
  logic [31:0]     r_pend;
  logic            r_rf_we;
  logic [4:0]      r_rf_rd;
  logic [XLEN-1:0] r_rf_wdata;
  // Set when the write currently on rf_* came from the LSU side (direct or
  // through hold); only those writes retire scoreboard entries.
  logic            r_rf_from_lsu;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic            w_alu_stall;
  logic            w_lsu_ready;
  logic            w_lsu_acc;
  logic            w_iss_stall;
  logic            w_iss_fire;
  src_e            w_src;
  logic [4:0]      w_wr_rd;
  logic [XLEN-1:0] w_wr_data;
  logic            w_hold_drain;
  logic            w_hold_fill;
  logic [CW-1:0]   w_starve_nxt;
  logic [31:0]     w_pend_nxt;

  assign w_lsu_ready = !r_hold_v;
  assign w_alu_stall = r_hold_v && (r_starve_cnt == STARVE_LIM);
  assign w_lsu_acc   = lsu_valid && w_lsu_ready;

  // r_pend[0] is always zero, so x0 never causes a hazard.
  assign w_iss_stall = iss_valid &&
                       (r_pend[iss_rs1] || r_pend[iss_rs2] || r_pend[iss_rd]);
  assign w_iss_fire  = iss_valid && !w_iss_stall && iss_long && (iss_rd != 5'd0);

  // Write-slot selection, highest priority first.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    w_src     = SRC_NONE;
    w_wr_rd   = r_rf_rd;
    w_wr_data = r_rf_wdata;
    if (w_alu_stall) begin
      // Starved hold entry wins; the ALU beat is ignored this cycle.
      w_src     = SRC_HOLD;
      w_wr_rd   = r_hold_rd;
      w_wr_data = r_hold_data;
    end else if (alu_valid && (alu_rd != 5'd0)) begin
      w_src     = SRC_ALU;
      w_wr_rd   = alu_rd;
      w_wr_data = alu_wdata;
    end else if (r_hold_v) begin
      w_src     = SRC_HOLD;
      w_wr_rd   = r_hold_rd;
      w_wr_data = r_hold_data;
    end else if (w_lsu_acc && (lsu_rd != 5'd0)) begin
      // Straight through, bypassing the hold buffer.
      w_src     = SRC_LSU;
      w_wr_rd   = lsu_rd;
      w_wr_data = lsu_wdata;
    end
  end

  assign w_hold_drain = (w_src == SRC_HOLD);
  // An accepted, non-x0 LSU beat that lost the slot to the ALU. Hold is empty
  // whenever an LSU beat is accepted, so this never collides with a drain.
  assign w_hold_fill  = (w_src == SRC_ALU) && w_lsu_acc && (lsu_rd != 5'd0);

  // Waiting time of the held entry; restarts whenever hold is empty or drains.
  always_comb begin
    w_starve_nxt = '0;
    if (r_hold_v && !w_hold_drain) begin
      if (r_starve_cnt != STARVE_LIM) begin
        w_starve_nxt = r_starve_cnt + CW'(1);
      end else begin
        w_starve_nxt = r_starve_cnt;
      end
    end
  end

  // Scoreboard update. The LSU write on rf_* commits at the coming edge, so its
  // pend bit is retired at that same edge. The WAW check on iss_rd keeps the
  // set and the clear off the same register.
  always_comb begin
    w_pend_nxt = r_pend;
    if (r_rf_we && r_rf_from_lsu) begin
      w_pend_nxt[r_rf_rd] = 1'b0;
    end
    if (w_iss_fire) begin
      w_pend_nxt[iss_rd] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_v      <= 1'b0;
      r_starve_cnt  <= '0;
      r_pend        <= '0;
      r_rf_we       <= 1'b0;
      r_rf_rd       <= 5'd0;
      r_rf_wdata    <= '0;
      r_rf_from_lsu <= 1'b0;
    end else begin
      r_starve_cnt  <= w_starve_nxt;
      r_pend        <= w_pend_nxt;
      r_rf_we       <= (w_src != SRC_NONE);
      r_rf_from_lsu <= (w_src == SRC_HOLD) || (w_src == SRC_LSU);
      if (w_src != SRC_NONE) begin
        r_rf_rd    <= w_wr_rd;
        r_rf_wdata <= w_wr_data;
      end
      if (w_hold_fill) begin
        r_hold_v <= 1'b1;
      end else if (w_hold_drain) begin
        r_hold_v <= 1'b0;
      end
    end
  end

  // NOTE: the hold payload has no reset; it is only ever read while r_hold_v
  // is set, and r_hold_v is reset, so clearing the data flops buys nothing.
  always_ff @(posedge clk) begin
    if (w_hold_fill) begin
      r_hold_rd   <= lsu_rd;
      r_hold_data <= lsu_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_stall = w_alu_stall;
  assign lsu_ready = w_lsu_ready;
  assign iss_stall = w_iss_stall;
  assign rf_we     = r_rf_we;
  assign rf_rd     = r_rf_rd;
  assign rf_wdata  = r_rf_wdata;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Self-checking bench for rf_wb_arbiter: a table of per-cycle vectors, two
// hand-written sequences (ALU starvation, reset with a buffered result), and a
// randomized run compared against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Each table row lists the rf_* values visible during that
// row's cycle, i.e. the result of the previous row's inputs.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_wdata;
  logic            alu_stall;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_wdata;
  logic            iss_valid;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic [4:0]      iss_rd;
  logic            iss_long;
  logic            iss_stall;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;

  rf_wb_arbiter #(
    .XLEN       (XLEN),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_wdata (alu_wdata),
    .alu_stall (alu_stall),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_wdata (lsu_wdata),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_long  (iss_long),
    .iss_stall (iss_stall),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        av;  logic [4:0] ar;  logic [31:0] ad;
    logic        lv;  logic [4:0] lr;  logic [31:0] ld;
    logic        iv;  logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic lg;
    logic        e_ready; logic e_astall; logic e_istall;
    logic        e_we; logic [4:0] e_rd; logic [31:0] e_wd;
  } vec_t;

  localparam int NVEC = 31;
  vec_t tbl [NVEC];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic lv, input logic [4:0] lr, input logic [31:0] ld,
    input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic lg,
    input logic e_ready, input logic e_astall, input logic e_istall,
    input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_wd);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad;
    v.lv = lv; v.lr = lr; v.ld = ld;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.lg = lg;
    v.e_ready = e_ready; v.e_astall = e_astall; v.e_istall = e_istall;
    v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_wdata = '0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_wdata = '0;
    iss_valid = 1'b0; iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd0; iss_long = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    alu_valid = v.av; alu_rd = v.ar; alu_wdata = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lr; lsu_wdata = v.ld;
    iss_valid = v.iv; iss_rs1 = v.rs1; iss_rs2 = v.rs2; iss_rd = v.rd; iss_long = v.lg;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: hold buffer as a queue, waiting time as a plain count,
  // scoreboard as a bit per register.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  bit          m_pend [32];
  wr_t         m_hold [$];
  int          m_wait;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  bit          m_from_lsu;

  function automatic void model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_hold.delete();
    m_wait     = 0;
    m_we       = 1'b0;
    m_rd       = 5'd0;
    m_wd       = '0;
    m_from_lsu = 1'b0;
  endfunction

  function automatic bit m_ready();
    return m_hold.size() == 0;
  endfunction

  function automatic bit m_astall();
    return (m_hold.size() != 0) && (m_wait >= STARVE_MAX);
  endfunction

  function automatic bit m_istall();
    return iss_valid && m_pend[iss_rs1] | m_pend[iss_rd] | m_pend[iss_rs2];
  endfunction

  // Advance the model across the coming rising edge using the current inputs.
  function automatic void model_step();
    bit  starved  = m_astall();
    bit  lsu_take = lsu_valid && m_ready();
    bit  alu_real = !starved && alu_valid && (alu_rd != 0);
    bit  iss_go   = iss_valid && !m_istall() && iss_long && (iss_rd != 0);
    bit  we       = 1'b0;
    bit  from_lsu = 1'b0;
    wr_t w;
    w.rd = m_rd; w.data = m_wd;
    if (m_we && m_from_lsu) m_pend[m_rd] = 1'b0;
    if (iss_go) m_pend[iss_rd] = 1'b1;
    if (starved || (!alu_real && m_hold.size() != 0)) begin
      w        = m_hold.pop_front();
      we       = 1'b1;
      from_lsu = 1'b1;
      m_wait   = 0;
    end else if (alu_real) begin
      we = 1'b1;
      w.rd = alu_rd; w.data = alu_wdata;
      if (m_hold.size() != 0) begin
        m_wait++;
      end else if (lsu_take && lsu_rd != 0) begin
        wr_t h;
        h.rd = lsu_rd; h.data = lsu_wdata;
        m_hold.push_back(h);
        m_wait = 0;
      end
    end else if (lsu_take && lsu_rd != 0) begin
      we = 1'b1;
      from_lsu = 1'b1;
      w.rd = lsu_rd; w.data = lsu_wdata;
    end
    m_we       = we;
    m_from_lsu = from_lsu;
    if (we) begin
      m_rd = w.rd;
      m_wd = w.data;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int pct;

    // Collision, rd=0 beats, direct LSU path, RAW/WAW and x0 issue cases.
    tbl[0]  = mk(0,0,0,           0,0,0,           0,0,0,0,0,   1,0,0, 0,0,0);
    tbl[1]  = mk(1,3,32'hAAAA,    1,4,32'hBBBB,    0,0,0,0,0,   1,0,0, 0,0,0);
    tbl[2]  = mk(0,0,0,           0,0,0,           0,0,0,0,0,   0,0,0, 1,3,32'hAAAA);
    tbl[3]  = mk(0,0,0,           0,0,0,           0,0,0,0,0,   1,0,0, 1,4,32'hBBBB);
    tbl[4]  = mk(0,0,0,           0,0,0,           0,0,0,0,0,   1,0,0, 0,4,32'hBBBB);
    tbl[5]  = mk(1,0,32'h5555,    1,0,32'h1234,    0,0,0,0,0,   1,0,0, 0,4,32'hBBBB);
    tbl[6]  = mk(0,0,0,           0,0,0,           0,0,0,0,0,   1,0,0, 0,4,32'hBBBB);
    tbl[7]  = mk(0,0,0,           1,6,32'h6666,    0,0,0,0,0,   1,0,0, 0,4,32'hBBBB);
    tbl[8]  = mk(0,0,0,           0,0,0,           0,0,0,0,0,   1,0,0, 1,6,32'h6666);
    tbl[9]  = mk(1,2,32'h2222,    0,0,0,           0,0,0,0,0,   1,0,0, 0,6,32'h6666);
    tbl[10] = mk(0,0,0,           0,0,0,           0,0,0,0,0,   1,0,0, 1,2,32'h2222);
    tbl[11] = mk(1,10,32'h0A0A,   1,0,32'hDEAD,    1,1,2,3,0,   1,0,0, 0,2,32'h2222);
    tbl[12] = mk(0,0,0,           0,0,0,           0,0,0,0,0,   1,0,0, 1,10,32'h0A0A);
    tbl[13] = mk(0,0,0,           0,0,0,           0,0,0,0,0,   1,0,0, 0,10,32'h0A0A);
    tbl[14] = mk(0,0,0,           0,0,0,           1,0,0,12,1,  1,0,0, 0,10,32'h0A0A);
    tbl[15] = mk(0,0,0,           0,0,0,           1,12,0,0,0,  1,0,1, 0,10,32'h0A0A);
    tbl[16] = mk(0,0,0,           0,0,0,           1,0,12,1,0,  1,0,1, 0,10,32'h0A0A);
    tbl[17] = mk(0,0,0,           0,0,0,           1,0,0,12,1,  1,0,1, 0,10,32'h0A0A);
    tbl[18] = mk(0,0,0,           1,12,32'hC0C0,   1,12,0,0,0,  1,0,1, 0,10,32'h0A0A);
    tbl[19] = mk(0,0,0,           0,0,0,           1,12,0,0,0,  1,0,1, 1,12,32'hC0C0);
    tbl[20] = mk(0,0,0,           0,0,0,           1,12,0,0,0,  1,0,0, 0,12,32'hC0C0);
    tbl[21] = mk(0,0,0,           0,0,0,           1,0,0,0,1,   1,0,0, 0,12,32'hC0C0);
    tbl[22] = mk(0,0,0,           0,0,0,           1,0,0,0,0,   1,0,0, 0,12,32'hC0C0);
    tbl[23] = mk(0,0,0,           0,0,0,           1,0,0,9,1,   1,0,0, 0,12,32'hC0C0);
    tbl[24] = mk(0,0,0,           0,0,0,           1,0,0,9,0,   1,0,1, 0,12,32'hC0C0);
    tbl[25] = mk(0,0,0,           1,14,32'hE0E0,   1,0,0,9,0,   1,0,1, 0,12,32'hC0C0);
    tbl[26] = mk(0,0,0,           0,0,0,           1,0,9,0,0,   1,0,1, 1,14,32'hE0E0);
    tbl[27] = mk(0,0,0,           0,0,0,           1,9,0,0,0,   1,0,1, 0,14,32'hE0E0);
    tbl[28] = mk(0,0,0,           1,9,32'h9999,    1,9,0,0,0,   1,0,1, 0,14,32'hE0E0);
    tbl[29] = mk(0,0,0,           0,0,0,           1,9,0,0,0,   1,0,1, 1,9,32'h9999);
    tbl[30] = mk(0,0,0,           0,0,0,           1,9,0,0,0,   1,0,0, 0,9,32'h9999);

    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d_lsu_ready", i), lsu_ready, tbl[i].e_ready);
      check($sformatf("vec%0d_alu_stall", i), alu_stall, tbl[i].e_astall);
      check($sformatf("vec%0d_iss_stall", i), iss_stall, tbl[i].e_istall);
      check($sformatf("vec%0d_rf_we", i),     rf_we,     tbl[i].e_we);
      check($sformatf("vec%0d_rf_rd", i),     rf_rd,     tbl[i].e_rd);
      check($sformatf("vec%0d_rf_wdata", i),  rf_wdata,  tbl[i].e_wd);
      next_cycle();
    end

    // Starvation: ALU writes every cycle while an LSU result sits in hold.
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_wdata = 32'h100;
    lsu_valid = 1'b1; lsu_rd = 5'd5;  lsu_wdata = 32'h5555;
    @(negedge clk);
    check("starve_fill_ready", lsu_ready, 1);
    next_cycle();
    for (int k = 1; k <= 5; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + k); alu_wdata = 32'(k);
      // Offered but must not be taken while hold is occupied.
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wdata = 32'h7777;
      @(negedge clk);
      check($sformatf("starve%0d_ready", k),     lsu_ready, 0);
      check($sformatf("starve%0d_alu_stall", k), alu_stall, (k == 5) ? 1 : 0);
      check($sformatf("starve%0d_rf_we", k),     rf_we,     1);
      check($sformatf("starve%0d_rf_rd", k),     rf_rd,     9 + k);
      check($sformatf("starve%0d_rf_wdata", k),  rf_wdata,  (k == 1) ? 32'h100 : 32'(k - 1));
      next_cycle();
    end
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd16; alu_wdata = 32'h6;
    @(negedge clk);
    check("starve_drain_alu_stall", alu_stall, 0);
    check("starve_drain_ready",     lsu_ready, 1);
    check("starve_drain_rf_we",     rf_we,     1);
    check("starve_drain_rf_rd",     rf_rd,     5);
    check("starve_drain_rf_wdata",  rf_wdata,  32'h5555);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("starve_resume_rf_rd",    rf_rd,    16);
    check("starve_resume_rf_wdata", rf_wdata, 32'h6);
    next_cycle();
    @(negedge clk);
    check("starve_quiet_rf_we", rf_we, 0);
    next_cycle();

    // Reset while a result is held and x5 is pending.
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wdata = 32'hAAAA;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_wdata = 32'hBBBB;
    iss_valid = 1'b1; iss_rd = 5'd5; iss_long = 1'b1;
    next_cycle();
    drive_idle();
    rst = 1'b1;
    iss_valid = 1'b1; iss_rs1 = 5'd5;
    @(negedge clk);
    check("rst_pre_ready",     lsu_ready, 0);
    check("rst_pre_iss_stall", iss_stall, 1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rf_we",     rf_we,     0);
    check("rst_rf_rd",     rf_rd,     0);
    check("rst_rf_wdata",  rf_wdata,  0);
    check("rst_ready",     lsu_ready, 1);
    check("rst_iss_stall", iss_stall, 0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("rst_hold_dropped_rf_we", rf_we, 0);
    next_cycle();

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      pct = (c < 1500) ? 85 : 45;
      alu_valid = ($urandom_range(0, 99) < pct);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_wdata = $urandom();
      lsu_valid = ($urandom_range(0, 99) < 40);
      lsu_rd    = 5'($urandom_range(0, 7));
      lsu_wdata = $urandom();
      iss_valid = ($urandom_range(0, 99) < 60);
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      iss_rd    = 5'($urandom_range(0, 7));
      iss_long  = ($urandom_range(0, 99) < 30);
      @(negedge clk);
      check("rnd_lsu_ready", lsu_ready, m_ready());
      check("rnd_alu_stall", alu_stall, m_astall());
      check("rnd_iss_stall", iss_stall, m_istall());
      check("rnd_rf_we",     rf_we,     m_we);
      check("rnd_rf_rd",     rf_rd,     m_rd);
      check("rnd_rf_wdata",  rf_wdata,  m_wd);
      model_step();
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
